// File: rtl/ebpc_enc_scheduler.sv
// Round-robin scheduler sharing one ebpc_encoder between N_REQ input streams.
// A grant is held from the first word of a stream until the encoder reports
// blk_done, so encoder output blocks never mix two streams.
module ebpc_enc_scheduler #(
    parameter int unsigned N_REQ  = 4,
    parameter int unsigned DATA_W = 8,
    parameter int unsigned CNT_W  = 16
) (
    input  logic                       clk_i,
    input  logic                       rst_ni,
    input  logic [N_REQ*DATA_W-1:0]    req_data_i,
    input  logic [N_REQ-1:0]           req_last_i,
    input  logic [N_REQ-1:0]           req_vld_i,
    output logic [N_REQ-1:0]           req_rdy_o,
    output logic [DATA_W-1:0]          enc_data_o,
    output logic                       enc_last_o,
    output logic                       enc_vld_o,
    input  logic                       enc_rdy_i,
    input  logic                       enc_idle_i,
    input  logic                       enc_blk_done_i,
    output logic [N_REQ-1:0]           grant_o,
    output logic                       done_vld_o,
    output logic [$clog2(N_REQ)-1:0]   done_idx_o,
    output logic [CNT_W-1:0]           done_cnt_o,
    output logic                       err_o
);

    localparam int unsigned IDX_W = $clog2(N_REQ);
    localparam logic [IDX_W:0] NReq = (IDX_W+1)'(N_REQ);

    typedef enum logic [1:0] {StIdle, StStream, StDrain} state_e;

    state_e             state_q, state_d;
    logic [IDX_W-1:0]   rr_q, rr_d;
    logic [IDX_W-1:0]   gidx_q, gidx_d;
    logic [N_REQ-1:0]   grant_q, grant_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               done_vld_q, done_vld_d;
    logic [IDX_W-1:0]   done_idx_q, done_idx_d;
    logic [CNT_W-1:0]   done_cnt_q, done_cnt_d;
    logic               err_q, err_d;

    logic               pick_vld;
    logic [IDX_W-1:0]   pick_idx;
    logic [IDX_W:0]     cand;
    logic               hs;

    // First valid requester at or after the rr pointer, wrapping past N_REQ-1
    always_comb begin
        pick_vld = 1'b0;
        pick_idx = '0;
        cand     = '0;
        for (int unsigned i = 0; i < N_REQ; i++) begin
            cand = {1'b0, rr_q} + (IDX_W+1)'(i);
            if (cand >= NReq) begin
                cand = cand - NReq;
            end
            if (!pick_vld && req_vld_i[cand[IDX_W-1:0]]) begin
                pick_vld = 1'b1;
                pick_idx = cand[IDX_W-1:0];
            end
        end
    end

    // Zero-latency pass-through of the granted requester while streaming
    always_comb begin
        enc_data_o = '0;
        enc_last_o = 1'b0;
        enc_vld_o  = 1'b0;
        req_rdy_o  = '0;
        if (state_q == StStream) begin
            enc_data_o        = req_data_i[gidx_q*DATA_W +: DATA_W];
            enc_last_o        = req_last_i[gidx_q];
            enc_vld_o         = req_vld_i[gidx_q];
            req_rdy_o[gidx_q] = enc_rdy_i;
        end
    end

    assign hs = enc_vld_o && enc_rdy_i;

    // Next-state: arbitration, word counting, drain completion and error flag
    always_comb begin
        state_d    = state_q;
        rr_d       = rr_q;
        gidx_d     = gidx_q;
        grant_d    = grant_q;
        cnt_d      = cnt_q;
        done_vld_d = 1'b0;
        done_idx_d = done_idx_q;
        done_cnt_d = done_cnt_q;
        // blk_done is only legal while draining; anything else is sticky error
        err_d      = err_q | (enc_blk_done_i && (state_q != StDrain));
        unique case (state_q)
            StIdle: begin
                if (pick_vld && enc_idle_i) begin
                    gidx_d  = pick_idx;
                    grant_d = {{(N_REQ-1){1'b0}}, 1'b1} << pick_idx;
                    cnt_d   = '0;
                    state_d = StStream;
                end
            end
            StStream: begin
                if (hs) begin
                    if (cnt_q != '1) begin
                        cnt_d = cnt_q + 1'b1;
                    end
                    if (enc_last_o) begin
                        state_d = StDrain;
                    end
                end
            end
            StDrain: begin
                if (enc_blk_done_i) begin
                    done_vld_d = 1'b1;
                    done_idx_d = gidx_q;
                    done_cnt_d = cnt_q;
                    rr_d       = (gidx_q == IDX_W'(N_REQ - 1)) ? '0 : gidx_q + 1'b1;
                    grant_d    = '0;
                    state_d    = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // State and output registers
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= StIdle;
            rr_q       <= '0;
            gidx_q     <= '0;
            grant_q    <= '0;
            cnt_q      <= '0;
            done_vld_q <= 1'b0;
            done_idx_q <= '0;
            done_cnt_q <= '0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            rr_q       <= rr_d;
            gidx_q     <= gidx_d;
            grant_q    <= grant_d;
            cnt_q      <= cnt_d;
            done_vld_q <= done_vld_d;
            done_idx_q <= done_idx_d;
            done_cnt_q <= done_cnt_d;
            err_q      <= err_d;
        end
    end

    assign grant_o    = grant_q;
    assign done_vld_o = done_vld_q;
    assign done_idx_o = done_idx_q;
    assign done_cnt_o = done_cnt_q;
    assign err_o      = err_q;

endmodule

// File: tb/tb_ebpc_enc_scheduler.sv
// Self-checking bench for ebpc_enc_scheduler with a bench-side encoder model.
module tb_ebpc_enc_scheduler;

    localparam int N  = 4;
    localparam int DW = 8;
    localparam int CW = 16;

    logic            clk_i = 1'b0;
    logic            rst_ni = 1'b0;
    logic [N*DW-1:0] req_data;
    logic [N-1:0]    req_last, req_vld, req_rdy;
    logic [DW-1:0]   enc_data;
    logic            enc_last, enc_vld, enc_rdy, enc_idle, enc_blk_done;
    logic [N-1:0]    grant;
    logic            done_vld;
    logic [1:0]      done_idx;
    logic [CW-1:0]   done_cnt;
    logic            err;

    always #5 clk_i = ~clk_i;

    ebpc_enc_scheduler #(.N_REQ(N), .DATA_W(DW), .CNT_W(CW)) dut (
        .clk_i          (clk_i),
        .rst_ni         (rst_ni),
        .req_data_i     (req_data),
        .req_last_i     (req_last),
        .req_vld_i      (req_vld),
        .req_rdy_o      (req_rdy),
        .enc_data_o     (enc_data),
        .enc_last_o     (enc_last),
        .enc_vld_o      (enc_vld),
        .enc_rdy_i      (enc_rdy),
        .enc_idle_i     (enc_idle),
        .enc_blk_done_i (enc_blk_done),
        .grant_o        (grant),
        .done_vld_o     (done_vld),
        .done_idx_o     (done_idx),
        .done_cnt_o     (done_cnt),
        .err_o          (err)
    );

    int errors = 0;
    int checks = 0;

    // Requester streams: words still to send are sdata[k][spos[k]..]
    logic [DW-1:0] sdata [N][$];
    int            spos  [N];

    // Reference model of ownership, round-robin pointer and completion reports
    int m_owner = -1, m_rr = 0, m_cnt = 0, m_done_idx = 0, m_done_cnt = 0;
    bit m_drain = 0, m_err = 0, m_done_exp = 0;
    int bd_wait = 0;
    bit spurious = 0;
    int rdy_mode = 0;
    int cyc = 0;
    int proto_bad = 0;

    // Observations
    int            obs_hs_idx[$];
    logic [DW-1:0] obs_hs_data[$];
    int            obs_done_idx[$];
    int            obs_done_cnt[$];
    int            exp_idx[$];
    logic [DW-1:0] exp_data[$];

    function automatic bit any_pending();
        for (int k = 0; k < N; k++) if (spos[k] < sdata[k].size()) return 1'b1;
        return 1'b0;
    endfunction

    task automatic load_stream(input int k, input int len);
        sdata[k].delete();
        for (int w = 0; w < len; w++) sdata[k].push_back(DW'($urandom));
        spos[k] = 0;
        for (int w = 0; w < len; w++) begin
            exp_idx.push_back(k);
            exp_data.push_back(sdata[k][w]);
        end
    endtask

    task automatic clear_logs();
        obs_hs_idx.delete(); obs_hs_data.delete();
        obs_done_idx.delete(); obs_done_cnt.delete();
        exp_idx.delete(); exp_data.delete();
        proto_bad = 0;
    endtask

    task automatic drive_inputs();
        for (int k = 0; k < N; k++) begin
            if (spos[k] < sdata[k].size()) begin
                req_vld[k]            = 1'b1;
                req_data[k*DW +: DW]  = sdata[k][spos[k]];
                req_last[k]           = (spos[k] == sdata[k].size() - 1);
            end else begin
                req_vld[k]            = 1'b0;
                req_data[k*DW +: DW]  = DW'($urandom);
                req_last[k]           = 1'($urandom);
            end
        end
        case (rdy_mode)
            0:       enc_rdy = 1'b1;
            1:       enc_rdy = (cyc % 2 == 0);
            default: enc_rdy = 1'($urandom);
        endcase
        enc_blk_done = (m_drain && bd_wait == 0) || spurious;
        enc_idle     = 1'b1;
    endtask

    // One clock: compare DUT against model, log events, advance model
    task automatic step();
        logic [N-1:0] eg, erdy, vld0;
        logic         evld;
        bit           hs, hs_last, bd, bad;
        int           owner0, gi, pick, k;
        #1;
        owner0 = m_owner;
        eg = '0; erdy = '0; evld = 1'b0;
        if (m_owner >= 0) eg[m_owner] = 1'b1;
        if (m_owner >= 0 && !m_drain) begin
            evld = req_vld[m_owner];
            erdy[m_owner] = enc_rdy;
        end
        bad = 0;
        if (grant !== eg || enc_vld !== evld || req_rdy !== erdy) bad = 1;
        if (evld && (enc_data !== sdata[m_owner][spos[m_owner]] ||
                     enc_last !== (spos[m_owner] == sdata[m_owner].size() - 1))) bad = 1;
        if (done_vld !== m_done_exp || err !== m_err) bad = 1;
        if (m_done_exp && (done_idx !== 2'(m_done_idx) || done_cnt !== CW'(m_done_cnt))) bad = 1;
        if (bad) proto_bad++;
        gi = -1;
        for (int j = 0; j < N; j++) if (grant[j]) gi = j;
        if (enc_vld && enc_rdy) begin
            obs_hs_idx.push_back(gi);
            obs_hs_data.push_back(enc_data);
        end
        if (done_vld) begin
            obs_done_idx.push_back(int'(done_idx));
            obs_done_cnt.push_back(int'(done_cnt));
        end
        hs      = evld && enc_rdy;
        hs_last = hs && (spos[m_owner] == sdata[m_owner].size() - 1);
        bd      = enc_blk_done;
        vld0    = req_vld;
        @(posedge clk_i);
        m_done_exp = 0;
        if (bd && !m_drain) m_err = 1;
        if (hs) begin
            if (m_cnt < (1 << CW) - 1) m_cnt++;
            spos[m_owner]++;
            if (hs_last) begin
                m_drain = 1;
                bd_wait = $urandom_range(0, 2);
            end
        end else if (m_drain && bd) begin
            m_done_exp = 1;
            m_done_idx = m_owner;
            m_done_cnt = m_cnt;
            m_rr       = (m_owner + 1) % N;
            m_owner    = -1;
            m_drain    = 0;
        end else if (m_drain && bd_wait > 0) begin
            bd_wait--;
        end
        if (owner0 < 0 && vld0 != '0 && enc_idle) begin
            pick = -1;
            for (int i = 0; i < N; i++) begin
                k = (m_rr + i) % N;
                if (pick < 0 && vld0[k]) pick = k;
            end
            m_owner = pick;
            m_cnt   = 0;
        end
        spurious = 0;
        cyc++;
        @(negedge clk_i);
        drive_inputs();
    endtask

    task automatic run(input int max_cyc, output bit to);
        int n = 0;
        to = 0;
        while ((any_pending() || m_owner >= 0) && n < max_cyc) begin
            step();
            n++;
        end
        if (n >= max_cyc) to = 1;
        step();
        step();
    endtask

    task automatic reset_model();
        m_owner = -1; m_rr = 0; m_cnt = 0; m_drain = 0; m_err = 0;
        m_done_exp = 0; bd_wait = 0; spurious = 0;
        for (int k = 0; k < N; k++) begin
            sdata[k].delete();
            spos[k] = 0;
        end
    endtask

    task automatic test_reset();
        reset_model();
        drive_inputs();
        #1;
        checks++;
        if ({grant, req_rdy, enc_vld, enc_last, enc_data, done_vld, done_idx, done_cnt, err} !== '0)
            begin errors++; $display("FAIL reset_outputs: got grant=%b rdy=%b vld=%b data=%h done=%b cnt=%0d err=%b want all zero",
                grant, req_rdy, enc_vld, enc_data, done_vld, done_cnt, err); end
        @(negedge clk_i);
        @(negedge clk_i);
        rst_ni = 1'b1;
        drive_inputs();
    endtask

    task automatic test_all_four();
        bit to;
        int exp_done[6] = '{0, 1, 2, 3, 0, 2};
        clear_logs();
        rdy_mode = 0;
        for (int k = 0; k < N; k++) load_stream(k, 3);
        drive_inputs();
        run(300, to);
        checks++; if (to !== 0) begin errors++; $display("FAIL all_four timeout: got %0d want 0", to); end
        load_stream(0, 3);
        load_stream(2, 3);
        drive_inputs();
        run(300, to);
        checks++; if (to !== 0) begin errors++; $display("FAIL all_four2 timeout: got %0d want 0", to); end
        checks++; if (proto_bad !== 0) begin errors++; $display("FAIL all_four protocol: got %0d bad cycles want 0", proto_bad); end
        checks++;
        if (obs_done_idx.size() !== 6) begin errors++; $display("FAIL all_four done_count: got %0d want 6", obs_done_idx.size()); end
        else for (int i = 0; i < 6; i++) begin
            checks++;
            if (obs_done_idx[i] !== exp_done[i] || obs_done_cnt[i] !== 3) begin errors++;
                $display("FAIL all_four done[%0d]: got idx=%0d cnt=%0d want idx=%0d cnt=3", i, obs_done_idx[i], obs_done_cnt[i], exp_done[i]); end
        end
        checks++;
        if (obs_hs_idx.size() !== 18) begin errors++; $display("FAIL all_four hs_count: got %0d want 18", obs_hs_idx.size()); end
        else for (int i = 0; i < 18; i++) begin
            checks++;
            if (obs_hs_idx[i] !== exp_idx[i] || obs_hs_data[i] !== exp_data[i]) begin errors++;
                $display("FAIL all_four hs[%0d]: got idx=%0d data=%h want idx=%0d data=%h", i, obs_hs_idx[i], obs_hs_data[i], exp_idx[i], exp_data[i]); end
        end
    endtask

    task automatic test_single_stream(input int k, input int len, input int mode, input string nm);
        bit to;
        clear_logs();
        rdy_mode = mode;
        load_stream(k, len);
        drive_inputs();
        run(200, to);
        checks++; if (to !== 0) begin errors++; $display("FAIL %s timeout: got %0d want 0", nm, to); end
        checks++; if (proto_bad !== 0) begin errors++; $display("FAIL %s protocol: got %0d bad cycles want 0", nm, proto_bad); end
        checks++;
        if (obs_done_idx.size() !== 1 || obs_done_idx[0] !== k || obs_done_cnt[0] !== len) begin errors++;
            $display("FAIL %s done: got n=%0d idx=%0d cnt=%0d want n=1 idx=%0d cnt=%0d", nm,
                obs_done_idx.size(), obs_done_idx.size() ? obs_done_idx[0] : -1,
                obs_done_cnt.size() ? obs_done_cnt[0] : -1, k, len); end
        checks++;
        if (obs_hs_idx.size() !== len) begin errors++; $display("FAIL %s hs_count: got %0d want %0d", nm, obs_hs_idx.size(), len); end
        else for (int i = 0; i < len; i++) begin
            checks++;
            if (obs_hs_idx[i] !== k || obs_hs_data[i] !== exp_data[i]) begin errors++;
                $display("FAIL %s hs[%0d]: got idx=%0d data=%h want idx=%0d data=%h", nm, i, obs_hs_idx[i], obs_hs_data[i], k, exp_data[i]); end
        end
    endtask

    task automatic test_spurious();
        bit to;
        int n = 0;
        clear_logs();
        rdy_mode = 0;
        load_stream(1, 6);
        drive_inputs();
        while (!(grant[1] && spos[1] == 1) && n < 20) begin step(); n++; end
        checks++; if (n >= 20) begin errors++; $display("FAIL spurious wait_stream: got timeout want grant"); end
        spurious = 1;
        drive_inputs();
        run(200, to);
        checks++; if (to !== 0) begin errors++; $display("FAIL spurious timeout: got %0d want 0", to); end
        checks++; if (err !== 1'b1) begin errors++; $display("FAIL spurious err_sticky: got %b want 1", err); end
        checks++; if (proto_bad !== 0) begin errors++; $display("FAIL spurious protocol: got %0d bad cycles want 0", proto_bad); end
        checks++;
        if (obs_done_idx.size() !== 1 || obs_done_idx[0] !== 1 || obs_done_cnt[0] !== 6) begin errors++;
            $display("FAIL spurious done: got n=%0d want idx=1 cnt=6", obs_done_idx.size()); end
    endtask

    task automatic test_wrap();
        bit to;
        // rr is 2 here; a stream on 2 moves it to 3
        test_single_stream(2, 2, 0, "wrap_prep");
        test_single_stream(2, 1, 0, "wrap_one_word");
        clear_logs();
        load_stream(1, 2);
        load_stream(3, 2);
        drive_inputs();
        run(200, to);
        checks++; if (to !== 0) begin errors++; $display("FAIL wrap_rr timeout: got %0d want 0", to); end
        checks++;
        if (obs_done_idx.size() !== 2 || obs_done_idx[0] !== 3 || obs_done_idx[1] !== 1) begin errors++;
            $display("FAIL wrap_rr order: got n=%0d first=%0d want 3 then 1", obs_done_idx.size(),
                obs_done_idx.size() ? obs_done_idx[0] : -1); end
    endtask

    task automatic test_random();
        bit to;
        int nload;
        int len[N];
        for (int r = 0; r < 6; r++) begin
            clear_logs();
            rdy_mode = 2;
            nload = 0;
            for (int k = 0; k < N; k++) begin
                len[k] = 0;
                if ($urandom_range(0, 1) == 1 || (k == N - 1 && nload == 0)) begin
                    len[k] = $urandom_range(1, 6);
                    load_stream(k, len[k]);
                    nload++;
                end
            end
            drive_inputs();
            run(400, to);
            checks++; if (to !== 0) begin errors++; $display("FAIL random[%0d] timeout: got %0d want 0", r, to); end
            checks++; if (proto_bad !== 0) begin errors++; $display("FAIL random[%0d] protocol: got %0d bad cycles want 0", r, proto_bad); end
            checks++;
            if (obs_done_idx.size() !== nload) begin errors++; $display("FAIL random[%0d] done_count: got %0d want %0d", r, obs_done_idx.size(), nload); end
            else for (int i = 0; i < nload; i++) begin
                checks++;
                if (obs_done_cnt[i] !== len[obs_done_idx[i]]) begin errors++;
                    $display("FAIL random[%0d] cnt idx %0d: got %0d want %0d", r, obs_done_idx[i], obs_done_cnt[i], len[obs_done_idx[i]]); end
            end
        end
    endtask

    task automatic test_reset_mid();
        bit to;
        int n = 0;
        clear_logs();
        rdy_mode = 0;
        load_stream(0, 8);
        drive_inputs();
        while (!(grant[0] && spos[0] >= 2) && n < 20) begin step(); n++; end
        checks++; if (n >= 20) begin errors++; $display("FAIL reset_mid wait_stream: got timeout want grant"); end
        checks++; if (err !== 1'b1) begin errors++; $display("FAIL reset_mid err_before: got %b want 1", err); end
        #2 rst_ni = 1'b0;
        #1;
        checks++;
        if ({grant, req_rdy, enc_vld, enc_last, enc_data, done_vld, done_idx, done_cnt, err} !== '0)
            begin errors++; $display("FAIL reset_mid outputs: got grant=%b rdy=%b vld=%b data=%h done=%b idx=%0d cnt=%0d err=%b want all zero",
                grant, req_rdy, enc_vld, enc_data, done_vld, done_idx, done_cnt, err); end
        reset_model();
        clear_logs();
        drive_inputs();
        @(negedge clk_i);
        rst_ni = 1'b1;
        // rr restarts at 0, so requester 1 wins over 3
        load_stream(3, 2);
        load_stream(1, 2);
        drive_inputs();
        run(200, to);
        checks++; if (to !== 0) begin errors++; $display("FAIL reset_mid timeout: got %0d want 0", to); end
        checks++; if (proto_bad !== 0) begin errors++; $display("FAIL reset_mid protocol: got %0d bad cycles want 0", proto_bad); end
        checks++;
        if (obs_done_idx.size() !== 2 || obs_done_idx[0] !== 1) begin errors++;
            $display("FAIL reset_mid rr_restart: got n=%0d first=%0d want first=1", obs_done_idx.size(),
                obs_done_idx.size() ? obs_done_idx[0] : -1); end
    endtask

    initial begin
        req_data = '0; req_last = '0; req_vld = '0;
        enc_rdy = 1'b0; enc_idle = 1'b1; enc_blk_done = 1'b0;
        test_reset();
        test_all_four();
        test_single_stream(0, 5, 0, "single_req0");
        test_single_stream(3, 8, 1, "rdy_toggle");
        test_spurious();
        test_wrap();
        test_random();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
